// File: rtl/mem_ctrl.sv
// mem_ctrl: memory-side target for the PicoRV32 native memory bus.
// Decodes each request into word RAM, a two-register UART transmitter,
// or an unmapped region, and answers with a one-cycle mem_ready pulse
// after a fixed number of wait cycles.
module mem_ctrl #(
    parameter int          RAM_WORDS    = 1024,
    parameter int          RAM_LATENCY  = 1,
    parameter logic [31:0] UART_BASE    = 32'h1000_0000,
    parameter int          CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        uart_tx,
    output logic        bus_err
);

    localparam int          AW          = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int          CW          = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [29:0] RAM_WORDS_W = 30'(RAM_WORDS);
    localparam logic [29:0] UART_DATA_W = UART_BASE[31:2];
    localparam logic [29:0] UART_STAT_W = UART_BASE[31:2] + 30'd1;
    localparam logic [3:0]  LATENCY     = 4'(RAM_LATENCY);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, WAIT, UART_STALL, RESP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q;
    logic [29:0]   word_addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic [31:0]   rdata_q;
    logic          bus_err_q;

    logic [31:0]   ram [RAM_WORDS];
    logic [AW-1:0] ram_idx;

    logic          tx_busy;
    logic          tx_q;
    logic [8:0]    tx_shift;
    logic [3:0]    tx_bit;
    logic [CW-1:0] tx_clk_cnt;
    logic          tx_start;

    logic access, is_ram, is_data, is_status, unmapped, read_op, uart_send;
    logic unused_inputs;

    // The fetch flag and the byte offset carry no meaning for this target.
    assign unused_inputs = &{1'b0, mem_instr, mem_addr[1:0]};

    assign ram_idx   = word_addr_q[AW-1:0];
    assign access    = (state_q == WAIT) && (cnt_q == 4'd0);
    assign is_ram    = word_addr_q < RAM_WORDS_W;
    assign is_data   = !is_ram && (word_addr_q == UART_DATA_W);
    assign is_status = !is_ram && (word_addr_q == UART_STAT_W);
    assign unmapped  = !is_ram && !is_data && !is_status;
    assign read_op   = (wstrb_q == 4'b0000);
    assign uart_send = is_data && wstrb_q[0];

    // State register; reset returns to IDLE, which also kills any pending ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a data write that finds the transmitter busy parks in UART_STALL.
    always_comb begin
        state_d  = state_q;
        tx_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_valid) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    if (uart_send && tx_busy) begin
                        state_d = UART_STALL;
                    end else begin
                        tx_start = uart_send;
                        state_d  = RESP;
                    end
                end
            end
            UART_STALL: begin
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Capture the request in IDLE and count down the wait cycles in WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_addr_q <= 30'd0;
            wdata_q     <= 32'd0;
            wstrb_q     <= 4'd0;
            cnt_q       <= 4'd0;
        end else if (state_q == IDLE && mem_valid) begin
            word_addr_q <= mem_addr[31:2];
            wdata_q     <= mem_wdata;
            wstrb_q     <= mem_wstrb;
            cnt_q       <= LATENCY;
        end else if (state_q == WAIT && cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    // RAM array with per-byte write enables; contents survive reset.
    always_ff @(posedge clk) begin
        if (access && is_ram && !read_op) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) begin
                    ram[ram_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    // Read data and the sticky error flag are settled on the access edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q   <= 32'd0;
            bus_err_q <= 1'b0;
        end else if (access) begin
            rdata_q <= 32'd0;
            if (read_op && is_ram) begin
                rdata_q <= ram[ram_idx];
            end else if (read_op && is_status) begin
                rdata_q <= {31'd0, tx_busy};
            end
            if (unmapped) begin
                bus_err_q <= 1'b1;
            end
        end
    end

    // 8N1 transmitter: start bit drives low on the start edge, busy drops after the stop bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_busy    <= 1'b0;
            tx_q       <= 1'b1;
            tx_shift   <= 9'h1FF;
            tx_bit     <= 4'd0;
            tx_clk_cnt <= '0;
        end else if (tx_start) begin
            tx_busy    <= 1'b1;
            tx_q       <= 1'b0;
            tx_shift   <= {1'b1, wdata_q[7:0]};
            tx_bit     <= 4'd0;
            tx_clk_cnt <= '0;
        end else if (tx_busy) begin
            if (tx_clk_cnt == BIT_LAST) begin
                tx_clk_cnt <= '0;
                if (tx_bit == 4'd9) begin
                    tx_busy <= 1'b0;
                    tx_q    <= 1'b1;
                end else begin
                    tx_bit   <= tx_bit + 4'd1;
                    tx_q     <= tx_shift[0];
                    tx_shift <= {1'b1, tx_shift[8:1]};
                end
            end else begin
                tx_clk_cnt <= tx_clk_cnt + 1'b1;
            end
        end
    end

    assign mem_ready = (state_q == RESP);
    assign mem_rdata = mem_ready ? rdata_q : 32'd0;
    assign uart_tx   = tx_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: drives bus requests into mem_ctrl and compares every
// output on every cycle against a transaction-level model of the target.
module tb_mem_ctrl;

    localparam int          WORDS = 64;
    localparam int          LAT   = 1;
    localparam int          CPB   = 4;
    localparam int          FRAME = 10 * CPB;
    localparam logic [31:0] UBASE = 32'h1000_0000;
    localparam logic [29:0] UWORD = UBASE[31:2];

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_valid = 1'b0;
    logic        mem_instr = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic [3:0]  mem_wstrb = 4'd0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        uart_tx;
    logic        bus_err;

    mem_ctrl #(
        .RAM_WORDS   (WORDS),
        .RAM_LATENCY (LAT),
        .UART_BASE   (UBASE),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .mem_valid(mem_valid),
        .mem_instr(mem_instr),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .uart_tx  (uart_tx),
        .bus_err  (bus_err)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          check_en = 1'b0;
    int          exp_ready_cyc = -1000;
    logic [31:0] exp_rdata = 32'd0;
    int          err_cyc = 32'h7FFF_FFFF;
    logic [31:0] mram [WORDS];
    int          fr_start[$];
    logic [7:0]  fr_data[$];
    logic        exp_rdy_c;

    int          lat;
    logic [31:0] rd;
    logic [9:0]  bits;

    // Posedge index; a value seen at a negedge belongs to the latest posedge.
    always @(posedge clk) cyc <= cyc + 1;

    // One comparison with a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Serial line level after posedge k, derived from the list of frames started so far.
    function automatic logic model_tx(input int k);
        int b;
        for (int i = 0; i < fr_start.size(); i++) begin
            if (k >= fr_start[i] && k < fr_start[i] + FRAME) begin
                b = (k - fr_start[i]) / CPB;
                if (b == 0) return 1'b0;
                if (b == 9) return 1'b1;
                return fr_data[i][b-1];
            end
        end
        return 1'b1;
    endfunction

    // Transmitter busy as seen by an access happening on posedge a.
    function automatic logic model_busy(input int a);
        int s;
        if (fr_start.size() == 0) return 1'b0;
        s = fr_start[fr_start.size()-1];
        return (s < a) && (a <= s + FRAME);
    endfunction

    // Work out when and what a request sampled on posedge e0 must answer.
    task automatic modelRequest(input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] wstrb, input int e0);
        int          a;
        int          r;
        int          w;
        logic [29:0] word;
        logic [31:0] rv;
        word = addr[31:2];
        a    = e0 + 1 + LAT;
        r    = a;
        rv   = 32'd0;
        if (word < 30'(WORDS)) begin
            w = int'(word);
            if (wstrb == 4'd0) begin
                rv = mram[w];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (wstrb[b]) mram[w][8*b +: 8] = wdata[8*b +: 8];
            end
        end else if (word == UWORD) begin
            if (wstrb[0]) begin
                if (model_busy(a)) r = fr_start[fr_start.size()-1] + FRAME + 1;
                fr_start.push_back(r);
                fr_data.push_back(wdata[7:0]);
            end
        end else if (word == UWORD + 30'd1) begin
            if (wstrb == 4'd0) rv = {31'd0, model_busy(a)};
        end else begin
            if (r < err_cyc) err_cyc = r;
        end
        exp_ready_cyc = r;
        exp_rdata     = rv;
    endtask

    // Forget everything a reset wipes out (RAM contents are kept).
    task automatic modelReset();
        exp_ready_cyc = -1000;
        exp_rdata     = 32'd0;
        err_cyc       = 32'h7FFF_FFFF;
        fr_start.delete();
        fr_data.delete();
    endtask

    // Issue one request, hold it until mem_ready, return latency and data.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] wstrb, output int l, output logic [31:0] r);
        int e0;
        bit seen;
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        mem_instr = 1'($urandom_range(0, 1));
        e0 = cyc + 1;
        modelRequest(addr, wdata, wstrb, e0);
        seen = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (mem_ready) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            tests++;
            failures++;
            $display("[TB] FAIL ready_timeout: got no mem_ready, expected one for addr 0x%08h", addr);
        end
        l = cyc - e0;
        r = mem_rdata;
        mem_valid = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_wstrb = 4'd0;
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (check_en && !reset) begin
            exp_rdy_c = (cyc == exp_ready_cyc);
            checkOutput("mem_ready", 32'(mem_ready), 32'(exp_rdy_c));
            checkOutput("mem_rdata", mem_rdata, exp_rdy_c ? exp_rdata : 32'd0);
            checkOutput("uart_tx", 32'(uart_tx), 32'(model_tx(cyc)));
            checkOutput("bus_err", 32'(bus_err), 32'(cyc >= err_cyc));
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed cases, randomized traffic, then resets in flight.
    initial begin
        repeat (2) @(negedge clk);
        checkOutput("reset_ready", 32'(mem_ready), 32'd0);
        checkOutput("reset_rdata", mem_rdata, 32'd0);
        checkOutput("reset_tx", 32'(uart_tx), 32'd1);
        checkOutput("reset_bus_err", 32'(bus_err), 32'd0);
        reset = 1'b0;
        modelReset();
        check_en = 1'b1;

        applyStimulus(32'h10, 32'hCAFE_F00D, 4'b1111, lat, rd);
        checkOutput("wr_latency", 32'(lat), 32'd2);
        applyStimulus(32'h10, 32'd0, 4'b0000, lat, rd);
        checkOutput("rd_latency", 32'(lat), 32'd2);
        checkOutput("rd_0x10", rd, 32'hCAFE_F00D);

        applyStimulus(32'h20, 32'h1122_3344, 4'b1111, lat, rd);
        applyStimulus(32'h20, 32'hAABB_CCDD, 4'b0101, lat, rd);
        applyStimulus(32'h20, 32'd0, 4'b0000, lat, rd);
        checkOutput("rd_strobe_merge", rd, 32'h11BB_33DD);

        applyStimulus(32'((WORDS - 1) * 4), 32'hDEAD_BEEF, 4'b1111, lat, rd);
        applyStimulus(32'((WORDS - 1) * 4), 32'd0, 4'b0000, lat, rd);
        checkOutput("rd_last_word", rd, 32'hDEAD_BEEF);

        applyStimulus(UBASE, 32'h0000_0055, 4'b0001, lat, rd);
        checkOutput("uart_wr_latency", 32'(lat), 32'd2);
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            bits[i] = uart_tx;
            repeat (CPB) @(negedge clk);
        end
        checkOutput("uart_frame_0x55", 32'(bits), 32'h0000_02AA);
        applyStimulus(UBASE + 32'd4, 32'd0, 4'b0000, lat, rd);
        checkOutput("status_idle", rd, 32'd0);
        applyStimulus(UBASE, 32'h0000_0000, 4'b0001, lat, rd);
        applyStimulus(UBASE + 32'd4, 32'd0, 4'b0000, lat, rd);
        checkOutput("status_busy", rd, 32'd1);
        applyStimulus(UBASE, 32'd0, 4'b0000, lat, rd);
        checkOutput("data_reg_read", rd, 32'd0);

        repeat (FRAME) @(negedge clk);
        applyStimulus(UBASE, 32'h0000_0041, 4'b0001, lat, rd);
        applyStimulus(UBASE, 32'h0000_0042, 4'b0001, lat, rd);
        checkOutput("queued_wr_latency", 32'(lat), 32'(FRAME - 1));

        checkOutput("bus_err_before", 32'(bus_err), 32'd0);
        applyStimulus(32'h2000_0000, 32'd0, 4'b0000, lat, rd);
        checkOutput("unmapped_latency", 32'(lat), 32'd2);
        checkOutput("unmapped_rdata", rd, 32'd0);
        checkOutput("bus_err_set", 32'(bus_err), 32'd1);
        applyStimulus(32'h10, 32'd0, 4'b0000, lat, rd);
        checkOutput("rd_after_err", rd, 32'hCAFE_F00D);
        checkOutput("bus_err_sticky", 32'(bus_err), 32'd1);
        applyStimulus(32'(WORDS * 4), 32'd0, 4'b0000, lat, rd);
        checkOutput("rd_past_ram", rd, 32'd0);

        for (int w = 0; w < 16; w++)
            applyStimulus(32'(w * 4), $urandom, 4'b1111, lat, rd);
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: applyStimulus(32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3)),
                                       $urandom, 4'($urandom_range(1, 15)), lat, rd);
                3, 4:    applyStimulus(32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3)),
                                       $urandom, 4'b0000, lat, rd);
                5, 6:    applyStimulus(UBASE + 32'($urandom_range(0, 3)), $urandom,
                                       4'($urandom_range(1, 15)), lat, rd);
                7:       applyStimulus(UBASE + 32'd4, 32'd0, 4'b0000, lat, rd);
                8:       applyStimulus(UBASE + 32'd4, $urandom, 4'($urandom_range(1, 15)), lat, rd);
                default: applyStimulus(32'h3000_0000 + 32'($urandom_range(0, 255) * 4),
                                       $urandom, 4'($urandom_range(0, 15)), lat, rd);
            endcase
        end

        @(negedge clk);
        check_en  = 1'b0;
        mem_valid = 1'b1;
        mem_addr  = 32'h10;
        mem_wstrb = 4'b0000;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("rst_wait_ready", 32'(mem_ready), 32'd0);
        checkOutput("rst_wait_rdata", mem_rdata, 32'd0);
        checkOutput("rst_wait_tx", 32'(uart_tx), 32'd1);
        checkOutput("rst_wait_bus_err", 32'(bus_err), 32'd0);
        mem_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rst_hold_ready", 32'(mem_ready), 32'd0);
        end
        reset = 1'b0;
        modelReset();
        check_en = 1'b1;
        repeat (5) @(negedge clk);

        applyStimulus(UBASE, 32'h0000_0055, 4'b0001, lat, rd);
        repeat (2) @(negedge clk);
        checkOutput("pre_rst_tx", 32'(uart_tx), 32'd0);
        check_en = 1'b0;
        reset = 1'b1;
        #1;
        checkOutput("rst_frame_tx", 32'(uart_tx), 32'd1);
        checkOutput("rst_frame_ready", 32'(mem_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        check_en = 1'b1;
        applyStimulus(UBASE + 32'd4, 32'd0, 4'b0000, lat, rd);
        checkOutput("status_after_rst", rd, 32'd0);
        checkOutput("bus_err_cleared", 32'(bus_err), 32'd0);
        repeat (3) @(negedge clk);

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory-side target for the CPU's PicoRV32 native memory interface. Accepts instruction fetches and load/store requests, decodes the address into a word-addressed RAM, a two-register UART transmitter, or an unmapped region, and returns a single-cycle `mem_ready` pulse after a fixed, parameterised latency. Sits directly downstream of the CPU core and is the only target on its bus.

## Interface
- `RAM_WORDS`, 1024: RAM depth in 32-bit words; RAM occupies byte addresses 0 .. 4*RAM_WORDS-1.
- `RAM_LATENCY`, 1: extra wait cycles (0..15) before `mem_ready` for every access.
- `UART_BASE`, 32'h1000_0000: UART data register; status register at `UART_BASE+4`.
- `CLKS_PER_BIT`, 868: UART bit period in clocks (≥2).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `mem_valid`  in  1  request valid; held with address/data stable until `mem_ready`.
- `mem_instr`  in  1  fetch indicator; ignored except for decode-free pass-through.
- `mem_addr`  in  32  byte address; bits [1:0] ignored.
- `mem_wdata`  in  32  write data.
- `mem_wstrb`  in  4  byte write enables; 0000 = read.
- `mem_ready`  out  1  one-cycle completion pulse.
- `mem_rdata`  out  32  read data, valid only while `mem_ready`=1, else 0.
- `uart_tx`  out  1  serial output, idle high.
- `bus_err`  out  1  sticky flag: an unmapped address was accessed.

## Operation
- FSM states: IDLE, WAIT, UART_STALL, RESP.
- IDLE: if `mem_valid`=1, latch addr/wdata/wstrb, load wait counter with `RAM_LATENCY`; go WAIT (or RESP-prep directly when `RAM_LATENCY`=0).
- WAIT: decrement counter; at 0 perform access: RAM read/write, UART register access, or error handling; go RESP, except UART data write while transmitter busy → UART_STALL.
- UART_STALL: remain until transmitter idle; then start transmit, go RESP.
- RESP: `mem_ready`=1, `mem_rdata` driven; next state IDLE unconditionally.
- RAM write: only bytes with strobe set are updated. RAM read: full word `ram[addr[31:2]]`.
- UART data write with `mem_wstrb[0]`=1: transmit `mem_wdata[7:0]` as 8N1, LSB first. `mem_wstrb[0]`=0: acknowledged, nothing sent. Reads of data register return 0.
- UART status read: `{31'b0, busy}`. Writes to status ignored, acknowledged.
- Unmapped address (read or write): acknowledged normally, `mem_rdata`=0, no side effect, `bus_err` set until reset.
- RAM contents not reset.

## Timing
- Reset values: `mem_ready`=0, `mem_rdata`=0, `uart_tx`=1, `bus_err`=0, FSM IDLE, transmitter idle, busy=0.
- Request sampled in IDLE at edge E0; `mem_ready` high during cycle E0+1+RAM_LATENCY (latency 2 cycles at default 1). Exactly one cycle wide.
- `mem_valid` still high in the cycle after RESP is a new request (back-to-back allowed; sampled on return to IDLE).
- UART: start bit begins on the edge that leaves UART_STALL/WAIT; frame = 10*CLKS_PER_BIT cycles; busy=1 from that edge until end of stop bit; a queued write starts the cycle after busy falls.
- `bus_err` rises on the edge entering RESP for an unmapped access.
- Reset mid-operation: FSM to IDLE, any pending `mem_ready` suppressed, UART frame aborted with `uart_tx`=1 immediately; partially counted latency discarded.

## Test plan
- Write 32'hCAFE_F00D to 0x10 (wstrb 1111), read 0x10 -> ready exactly 2 cycles after each request at RAM_LATENCY=1, rdata 32'hCAFE_F00D.
- Write 32'h1122_3344 to 0x20, then 32'hAABB_CCDD with wstrb 0101 -> read returns 32'h11BB_33DD.
- Write 0x55 to UART_BASE with CLKS_PER_BIT=4 -> `uart_tx` low 4 cycles, then bits 1,0,1,0,1,0,1,0 each 4 cycles, stop high; status reads 1 during frame, 0 after.
- Two back-to-back UART writes 0x41, 0x42 -> second `mem_ready` withheld until first stop bit ends; 0x42 frame follows without gap beyond one cycle.
- Read 0x2000_0000 -> ready after 2 cycles, rdata 0, `bus_err`=1 and stays 1 across later good accesses.
- Assert `reset` during WAIT and mid-UART frame -> no `mem_ready` pulse, `uart_tx`=1 same cycle, status 0 after release.
